// File: rtl/adsr_pkg.sv
// ============================================================================
// Module      : adsr_pkg
// Description : Shared types and constants for the ADSR envelope stage:
//               state encodings, sample/rate widths and envelope full scale.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adsr_pkg;

    // Oscillator sample width (signed) and envelope rate input width.
    localparam int SAMPLE_WIDTH = 16;
    localparam int RATE_WIDTH   = 16;

    // Envelope full scale for the default 16-bit level.
    localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

    // Encodings are visible on the debug state output; keep them stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

`default_nettype wire

// File: rtl/sample_tick_gen.sv
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running divider producing a one-cycle tick every
//               SAMPLE_DIV clocks. The tick is high while the counter holds
//               SAMPLE_DIV-1, so the first tick after reset is seen in the
//               SAMPLE_DIV-th cycle.
// Ports       : i_Clk   - system clock
//               i_Reset - synchronous active-high reset (counter to 0)
//               o_Tick  - one-cycle sample tick
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_tick_gen #(
    parameter int SAMPLE_DIV = 512
) (
    input  logic i_Clk,
    input  logic i_Reset,
    output logic o_Tick
);

    localparam int                 c_cnt_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SAMPLE_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_Tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/adsr_envelope.sv
// ============================================================================
// Module      : adsr_envelope
// Description : ADSR amplitude envelope between oscillator and I2S output.
//               Note events are latched and acted on at the next sample tick;
//               the envelope level steps once per tick and scales the signed
//               input sample. o_Sample is taken from the level held before
//               each tick's update, so it trails the envelope by one tick.
// Config      : ADSR_LEGATO_EN - when defined, note-on during ATTACK, DECAY
//               or SUSTAIN does not retrigger the attack phase.
// Ports       : i_Clk, i_Reset          - clock, sync active-high reset
//               i_Note_On, i_Note_Off   - single-cycle note event pulses
//               i_Sample                - signed oscillator sample
//               i_Attack_Rate           - level increment per tick (0 = jump)
//               i_Decay_Rate            - level decrement per tick (0 = jump)
//               i_Sustain_Level         - sustain level, tracked live
//               i_Release_Rate          - level decrement per tick (0 = jump)
//               o_Sample                - enveloped signed sample
//               o_Sample_Valid          - one-cycle pulse after each tick
//               o_Active                - state is not IDLE
//               o_State                 - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int SAMPLE_DIV  = 512,
    parameter int LEVEL_WIDTH = $bits(LEVEL_MAX)
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Note_On,
    input  logic                           i_Note_Off,
    input  logic signed [SAMPLE_WIDTH-1:0] i_Sample,
    input  logic        [RATE_WIDTH-1:0]   i_Attack_Rate,
    input  logic        [RATE_WIDTH-1:0]   i_Decay_Rate,
    input  logic        [LEVEL_WIDTH-1:0]  i_Sustain_Level,
    input  logic        [RATE_WIDTH-1:0]   i_Release_Rate,
    output logic signed [SAMPLE_WIDTH-1:0] o_Sample,
    output logic                           o_Sample_Valid,
    output logic                           o_Active,
    output logic        [2:0]              o_State
);

    localparam int                     c_ext_w  = LEVEL_WIDTH + 1;
    localparam int                     c_prod_w = SAMPLE_WIDTH + LEVEL_WIDTH + 1;
    localparam logic [LEVEL_WIDTH-1:0] c_full   = {LEVEL_WIDTH{1'b1}};

    logic w_tick;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .o_Tick  (w_tick)
    );

    adsr_state_t                    r_state;
    logic        [LEVEL_WIDTH-1:0]  r_level;
    logic                           r_pend_on;
    logic                           r_pend_off;
    logic signed [SAMPLE_WIDTH-1:0] r_sample_out;
    logic                           r_sample_valid;

    // One extra bit of headroom makes the carry/borrow the saturation flag.
    logic [c_ext_w-1:0] w_level_ext;
    logic [c_ext_w-1:0] w_att_sum;
    logic [c_ext_w-1:0] w_dec_diff;
    logic [c_ext_w-1:0] w_rel_diff;
    logic               w_att_done;
    logic               w_dec_done;
    logic               w_rel_done;
    logic               w_in_note;
    logic               w_retrigger_ok;

    assign w_level_ext = {1'b0, r_level};
    assign w_att_sum   = w_level_ext + c_ext_w'(i_Attack_Rate);
    assign w_dec_diff  = w_level_ext - c_ext_w'(i_Decay_Rate);
    assign w_rel_diff  = w_level_ext - c_ext_w'(i_Release_Rate);

    // A zero rate finishes its phase on the first tick regardless of level.
    assign w_att_done = (i_Attack_Rate == '0) || (w_att_sum >= {1'b0, c_full});
    assign w_dec_done = (i_Decay_Rate == '0) || w_dec_diff[LEVEL_WIDTH] ||
                        (w_dec_diff[LEVEL_WIDTH-1:0] <= i_Sustain_Level);
    assign w_rel_done = (i_Release_Rate == '0) || w_rel_diff[LEVEL_WIDTH] ||
                        (w_rel_diff[LEVEL_WIDTH-1:0] == '0);

    assign w_in_note = (r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                       (r_state == ST_SUSTAIN);

`ifdef ADSR_LEGATO_EN
    assign w_retrigger_ok = !w_in_note;
`else
    assign w_retrigger_ok = 1'b1;
`endif

    // Level is zero-extended so the product stays a plain signed scaling.
    logic signed [c_prod_w-1:0]     w_product;
    logic signed [SAMPLE_WIDTH-1:0] w_sample_scaled;
    logic                           w_unused_prod_bits;

    assign w_product          = $signed(i_Sample) * $signed(w_level_ext);
    assign w_sample_scaled    = w_product[c_prod_w-2:LEVEL_WIDTH];
    assign w_unused_prod_bits = ^{w_product[c_prod_w-1], w_product[LEVEL_WIDTH-1:0]};

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state        <= ST_IDLE;
            r_level        <= '0;
            r_pend_on      <= 1'b0;
            r_pend_off     <= 1'b0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            // Newest event wins; an event arriving on the tick cycle itself
            // is kept for the following tick rather than cleared.
            if (i_Note_On) begin
                r_pend_on  <= 1'b1;
                r_pend_off <= 1'b0;
            end else if (i_Note_Off) begin
                r_pend_on  <= 1'b0;
                r_pend_off <= 1'b1;
            end else if (w_tick) begin
                r_pend_on  <= 1'b0;
                r_pend_off <= 1'b0;
            end

            r_sample_valid <= w_tick;

            if (w_tick) begin
                r_sample_out <= w_sample_scaled;

                // Event ticks only change state; the level is carried over.
                if (r_pend_on && w_retrigger_ok) begin
                    r_state <= ST_ATTACK;
                end else if (r_pend_off && w_in_note) begin
                    r_state <= ST_RELEASE;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_level <= r_level;
                        end
                        ST_ATTACK: begin
                            if (w_att_done) begin
                                r_level <= c_full;
                                r_state <= ST_DECAY;
                            end else begin
                                r_level <= w_att_sum[LEVEL_WIDTH-1:0];
                            end
                        end
                        ST_DECAY: begin
                            if (w_dec_done) begin
                                r_level <= i_Sustain_Level;
                                r_state <= ST_SUSTAIN;
                            end else begin
                                r_level <= w_dec_diff[LEVEL_WIDTH-1:0];
                            end
                        end
                        ST_SUSTAIN: begin
                            r_level <= i_Sustain_Level;
                        end
                        ST_RELEASE: begin
                            if (w_rel_done) begin
                                r_level <= '0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_level <= w_rel_diff[LEVEL_WIDTH-1:0];
                            end
                        end
                        default: begin
                            r_level <= '0;
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign o_Sample       = r_sample_out;
    assign o_Sample_Valid = r_sample_valid;
    assign o_Active       = (r_state != ST_IDLE);
    assign o_State        = r_state;

endmodule

`default_nettype wire

// File: doc/adsr_envelope.md
# adsr_envelope

ADSR amplitude envelope stage between the oscillator waveform output and the I2S transmitter. Consumes the single-cycle note-on/note-off pulses from the MIDI interpreter and scales the 16-bit signed oscillator sample by a 16-bit envelope level. The envelope advances once per audio sample period, aligned to the I2S sample rate, so that notes start and stop without clicks.

## Interface
- SAMPLE_DIV, 512: clock cycles per sample tick; matches the I2S divisor.
- LEVEL_WIDTH, 16: envelope level width, unsigned; full scale is 2^LEVEL_WIDTH-1.
- i_Clk  in  1  system clock (25 MHz).
- i_Reset  in  1  reset. Synchronous, active-high, single clock domain.
- i_Note_On  in  1  single-cycle pulse from the MIDI interpreter.
- i_Note_Off  in  1  single-cycle pulse from the MIDI interpreter.
- i_Sample  in  16  signed oscillator sample.
- i_Attack_Rate  in  16  level increment per tick; 0 = instantaneous.
- i_Decay_Rate  in  16  level decrement per tick; 0 = instantaneous.
- i_Sustain_Level  in  16  sustain level, unsigned.
- i_Release_Rate  in  16  level decrement per tick; 0 = instantaneous.
- o_Sample  out  16  signed enveloped sample, feeds the I2S left/right inputs.
- o_Sample_Valid  out  1  one-cycle pulse when o_Sample updates.
- o_Active  out  1  high whenever the state is not IDLE.
- o_State  out  3  current state encoding, for debug.

## Operation
- Tick counter counts 0..SAMPLE_DIV-1; the tick fires in the cycle the counter equals SAMPLE_DIV-1.
- Note events are latched into a pending register on any cycle and consumed on the next tick. A later event overwrites an earlier one. Note-on and note-off in the same cycle latch as note-on.
- States and encodings: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. All transitions happen only on a tick.
- Pending note-on, from any state: go to ATTACK. The level is kept; there is no reset to 0, so a retrigger from RELEASE starts at the current level.
- Pending note-off in ATTACK, DECAY or SUSTAIN: go to RELEASE. In IDLE or RELEASE it is ignored.
- ATTACK: level += attack rate, saturating at full scale. On reaching full scale, go to DECAY.
- DECAY: level -= decay rate, clamped at i_Sustain_Level. On reaching the sustain level, go to SUSTAIN.
- SUSTAIN: level = i_Sustain_Level every tick; the sustain input is tracked live.
- RELEASE: level -= release rate, saturating at 0. On reaching 0, go to IDLE.
- All add/subtract operations use LEVEL_WIDTH+1 bits so saturation is exact, with no wrap-around.
- Output: o_Sample = (i_Sample × {1'b0, level}) >>> LEVEL_WIDTH. The multiply is 16×17 signed into a 33-bit product; take product bits [31:16].

## Timing
- Reset values: state IDLE, level 0, tick counter 0, pending flags cleared, o_Sample 0, o_Sample_Valid 0, o_Active 0, o_State 0.
- On the tick edge, o_Sample is registered from the current i_Sample and the pre-update level, and the level and state update on the same edge. The output therefore lags the envelope by one tick.
- o_Sample_Valid is high during the cycle after the tick edge, i.e. one pulse per SAMPLE_DIV cycles.
- Event-to-effect latency: at most SAMPLE_DIV cycles to the state change, plus one tick to appear on o_Sample.
- Reset asserted mid-note: everything returns to reset values on the next edge, and pending events are dropped.
- Rate 0 completes its phase in exactly one tick.

## Configuration
- ADSR_LEGATO_EN defined: a pending note-on while in ATTACK, DECAY or SUSTAIN is ignored (no retrigger). From IDLE or RELEASE it still goes to ATTACK.
- ADSR_LEGATO_EN undefined: a note-on always retriggers ATTACK, as described in Operation.

## Structure
- Package adsr_pkg holds the state enum and its encodings, LEVEL_MAX, and the sample and rate width constants.
- Sub-module sample_tick_gen, parameterised by SAMPLE_DIV, produces the tick pulse. The I2S block can reuse it.
- The state machine, level arithmetic and output multiply stay in adsr_envelope.

## Test plan
- After reset with i_Sample=16'h4000 and no events: o_Sample stays 0, o_Active=0, and o_Sample_Valid pulses every 512 cycles.
- Attack=16384, decay=8192, sustain=32768, i_Sample=16'h7FFF, then note-on: ATTACK for 4 ticks (level saturates at 65535), DECAY for 4 ticks, SUSTAIN with o_Sample=16'h3FFF.
- Note-off while in SUSTAIN with release=8192: level goes 32768→0 in 4 ticks, state reaches IDLE, o_Active falls, o_Sample ends at 0.
- Note-on and note-off pulsed in the same cycle while IDLE: ATTACK is entered on the next tick.
- Note-on during RELEASE at level 20000: ATTACK resumes from 20000, not from 0. With ADSR_LEGATO_EN, a note-on in SUSTAIN leaves the state at SUSTAIN.
- All rates 0, note-on: one tick each in ATTACK (level 65535) and DECAY, then SUSTAIN. Reset asserted mid-ATTACK: all outputs are 0 on the next cycle.
